// File: rtl/reaction_game_multi_fsm_if.sv
// -----------------------------------------------------------------------------
// reaction_game_multi_fsm_if
//   Bundles the game controller's inputs (ms strobe, start button, switches,
//   LFSR value) and its display/status outputs into one interface.
//   ms_tick is a plain strobe: every cycle it is high counts as one millisecond.
//   There is no backpressure anywhere on this interface.
//
//   master : the environment side (tick generator, LFSR, switches, displays)
//   slave  : the game controller
//
//   ms_tick      master->slave  1                    millisecond strobe
//   start_btn    master->slave  1                    synchronised button level
//   switches     master->slave  LED_NUM              player switches
//   rand_value   master->slave  $clog2(LED_NUM)      LFSR value
//   led_on       slave->master  LED_NUM              lit target mask
//   score        slave->master  10                   hit count (saturating)
//   level        slave->master  $clog2(MAX_LEVEL+1)  difficulty level
//   lives_left   slave->master  $clog2(LIVES+1)      remaining lives
//   time_left_s  slave->master  $clog2(GAME_S+1)     seconds remaining
//   game_over    slave->master  1                    game finished
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface reaction_game_multi_fsm_if #(
  parameter int LED_NUM   = 18,
  parameter int MAX_LEVEL = 15,
  parameter int LIVES     = 3,
  parameter int GAME_S    = 60
);
  localparam int IDX_W  = $clog2(LED_NUM);
  localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
  localparam int LIV_W  = $clog2(LIVES + 1);
  localparam int TIME_W = $clog2(GAME_S + 1);

  logic               ms_tick;
  logic               start_btn;
  logic [LED_NUM-1:0] switches;
  logic [IDX_W-1:0]   rand_value;
  logic [LED_NUM-1:0] led_on;
  logic [9:0]         score;
  logic [LVL_W-1:0]   level;
  logic [LIV_W-1:0]   lives_left;
  logic [TIME_W-1:0]  time_left_s;
  logic               game_over;

  modport master (
    output ms_tick, start_btn, switches, rand_value,
    input  led_on, score, level, lives_left, time_left_s, game_over
  );

  modport slave (
    input  ms_tick, start_btn, switches, rand_value,
    output led_on, score, level, lives_left, time_left_s, game_over
  );
endinterface

// File: rtl/reaction_game_multi_fsm.sv
// -----------------------------------------------------------------------------
// reaction_game_multi_fsm
//   Reaction-game controller. Each round it goes dark for GAP_MS, lights
//   1..MAX_TARGETS distinct LEDs chosen from the LFSR, then grades the player's
//   switch toggles against the lit set within a level-dependent window.
//   Tracks score, level, lives and a GAME_S-second game clock.
//
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of reaction_game_multi_fsm_if (all game I/O)
//   dbg_state  out  current FSM state code (IDLE=0 GAP=1 PICK=2 WAIT=3
//                   HIT=4 MISS=5 OVER=6)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module reaction_game_multi_fsm #(
  parameter int LED_NUM        = 18,
  parameter int MAX_TARGETS    = 4,
  parameter int BASE_WINDOW_MS = 1000,
  parameter int STEP_MS        = 150,
  parameter int MIN_WINDOW_MS  = 250,
  parameter int GAP_MS         = 500,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 15,
  parameter int LIVES          = 3,
  parameter int GAME_S         = 60
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reaction_game_multi_fsm_if.slave bus,
  output logic [2:0]               dbg_state
);

  localparam int IDX_W  = $clog2(LED_NUM);
  localparam int LVL_W  = $clog2(MAX_LEVEL + 1);
  localparam int LIV_W  = $clog2(LIVES + 1);
  localparam int TIME_W = $clog2(GAME_S + 1);
  localparam int NEED_W = $clog2(MAX_TARGETS + 1);
  localparam int HPL_W  = $clog2(HITS_PER_LEVEL + 1);
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_PICK = 3'd2,
    S_WAIT = 3'd3,
    S_HIT  = 3'd4,
    S_MISS = 3'd5,
    S_OVER = 3'd6
  } state_t;

  state_t             state;
  logic               start_q;
  logic [LED_NUM-1:0] mask_q;
  logic [LED_NUM-1:0] snap_q;
  logic [LED_NUM-1:0] led_q;
  logic [IDX_W-1:0]   probe_q;
  logic               probing_q;
  logic [NEED_W-1:0]  pick_cnt_q;
  logic [CNT_W-1:0]   gap_cnt_q;
  logic [CNT_W-1:0]   win_cnt_q;
  logic [9:0]         game_ms_q;
  logic [TIME_W-1:0]  time_q;
  logic [9:0]         score_q;
  logic [LVL_W-1:0]   level_q;
  logic [HPL_W-1:0]   lvl_hits_q;
  logic [LIV_W-1:0]   lives_q;
  logic               over_q;

  // Combinational helpers
  logic               start_edge;
  logic               playing;
  logic               enter_idle;
  logic [IDX_W-1:0]   rand_cand;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   next_probe;
  logic [LED_NUM-1:0] pick_mask;
  logic [NEED_W-1:0]  need;
  logic [NEED_W-1:0]  pick_cnt_inc;
  logic [CNT_W-1:0]   win_len;
  logic [LED_NUM-1:0] tog;
  logic               is_hit;
  logic               wrong_sw;
  logic               timeout;
  logic               sec_tick;
  logic               time_zero_next;
  int                 need_i;
  int                 red_i;

  always_comb begin
    start_edge = bus.start_btn & ~start_q;
    playing    = (state == S_GAP) || (state == S_PICK) || (state == S_WAIT) ||
                 (state == S_HIT) || (state == S_MISS);
    // A start edge during play or in OVER always lands in IDLE.
    enter_idle = start_edge && (playing || (state == S_OVER));

    // Candidate is either fresh LFSR value or the linear probe after a collision.
    rand_cand  = IDX_W'(int'(bus.rand_value) % LED_NUM);
    cand       = probing_q ? probe_q : rand_cand;
    next_probe = (cand == IDX_W'(LED_NUM - 1)) ? '0 : cand + IDX_W'(1);
    pick_mask       = mask_q;
    pick_mask[cand] = 1'b1;

    need_i = int'(level_q) + 1;
    if (need_i > MAX_TARGETS) need_i = MAX_TARGETS;
    need         = NEED_W'(need_i);
    pick_cnt_inc = pick_cnt_q + NEED_W'(1);

    // Clamp before subtracting so the window never wraps below the floor.
    red_i = int'(level_q) * STEP_MS;
    if (red_i >= BASE_WINDOW_MS - MIN_WINDOW_MS) win_len = CNT_W'(MIN_WINDOW_MS);
    else                                         win_len = CNT_W'(BASE_WINDOW_MS - red_i);

    tog      = bus.switches ^ snap_q;
    is_hit   = (tog == mask_q);
    wrong_sw = |(tog & ~mask_q);
    timeout  = bus.ms_tick && (win_cnt_q == win_len - CNT_W'(1));

    sec_tick       = playing && bus.ms_tick && (game_ms_q == 10'd999);
    time_zero_next = (time_q == '0) || ((time_q == TIME_W'(1)) && sec_tick);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mask_q     <= '0;
      snap_q     <= '0;
      led_q      <= '0;
      probe_q    <= '0;
      probing_q  <= 1'b0;
      pick_cnt_q <= '0;
      gap_cnt_q  <= '0;
      win_cnt_q  <= '0;
      game_ms_q  <= '0;
      time_q     <= TIME_W'(GAME_S);
      score_q    <= '0;
      level_q    <= '0;
      lvl_hits_q <= '0;
      lives_q    <= LIV_W'(LIVES);
      over_q     <= 1'b0;
    end else begin
      start_q <= bus.start_btn;

      // Game clock: runs in every play state; seconds hold at zero.
      if (playing && bus.ms_tick) begin
        if (game_ms_q == 10'd999) begin
          game_ms_q <= '0;
          if (time_q != '0) time_q <= time_q - TIME_W'(1);
        end else begin
          game_ms_q <= game_ms_q + 10'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state     <= S_GAP;
            gap_cnt_q <= '0;
            game_ms_q <= '0;
            led_q     <= '0;
          end
        end

        S_GAP: begin
          if (time_zero_next) begin
            state  <= S_OVER;
            over_q <= 1'b1;
            led_q  <= mask_q;
          end else if (bus.ms_tick) begin
            if (gap_cnt_q == CNT_W'(GAP_MS - 1)) begin
              state      <= S_PICK;
              mask_q     <= '0;
              pick_cnt_q <= '0;
              probing_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + CNT_W'(1);
            end
          end
        end

        S_PICK: begin
          if (time_zero_next) begin
            state  <= S_OVER;
            over_q <= 1'b1;
            led_q  <= mask_q;
          end else if (mask_q[cand]) begin
            probing_q <= 1'b1;
            probe_q   <= next_probe;
          end else begin
            mask_q     <= pick_mask;
            probing_q  <= 1'b0;
            pick_cnt_q <= pick_cnt_inc;
            if (pick_cnt_inc == need) begin
              state     <= S_WAIT;
              snap_q    <= bus.switches;
              win_cnt_q <= '0;
              led_q     <= pick_mask;
            end
          end
        end

        S_WAIT: begin
          if (is_hit) begin
            state <= S_HIT;
          end else if (wrong_sw || timeout) begin
            state <= S_MISS;
          end else if (time_zero_next) begin
            state  <= S_OVER;
            over_q <= 1'b1;
          end else if (bus.ms_tick) begin
            win_cnt_q <= win_cnt_q + CNT_W'(1);
          end
        end

        S_HIT: begin
          if (score_q != 10'd1023) begin
            score_q <= score_q + 10'd1;
            if (lvl_hits_q == HPL_W'(HITS_PER_LEVEL - 1)) begin
              lvl_hits_q <= '0;
              if (level_q != LVL_W'(MAX_LEVEL)) level_q <= level_q + LVL_W'(1);
            end else begin
              lvl_hits_q <= lvl_hits_q + HPL_W'(1);
            end
          end
          if (time_zero_next) begin
            state  <= S_OVER;
            over_q <= 1'b1;
          end else begin
            state     <= S_GAP;
            gap_cnt_q <= '0;
            led_q     <= '0;
          end
        end

        S_MISS: begin
          lives_q <= lives_q - LIV_W'(1);
          if ((lives_q == LIV_W'(1)) || time_zero_next) begin
            state  <= S_OVER;
            over_q <= 1'b1;
          end else begin
            state     <= S_GAP;
            gap_cnt_q <= '0;
            led_q     <= '0;
          end
        end

        S_OVER: begin
          // Everything frozen; only a start edge leaves (handled below).
        end

        default: state <= S_IDLE;
      endcase

      // Abort / restart overrides any transition chosen above.
      if (enter_idle) begin
        state      <= S_IDLE;
        over_q     <= 1'b0;
        led_q      <= '0;
        score_q    <= '0;
        level_q    <= '0;
        lvl_hits_q <= '0;
        lives_q    <= LIV_W'(LIVES);
        time_q     <= TIME_W'(GAME_S);
        game_ms_q  <= '0;
      end
    end
  end

  assign bus.led_on      = led_q;
  assign bus.score       = score_q;
  assign bus.level       = level_q;
  assign bus.lives_left  = lives_q;
  assign bus.time_left_s = time_q;
  assign bus.game_over   = over_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_reaction_game_multi_fsm.sv
`timescale 1ns/1ps
module tb_reaction_game_multi_fsm;

  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T_GAP  = 3'd1;
  localparam logic [2:0] T_PICK = 3'd2;
  localparam logic [2:0] T_WAIT = 3'd3;
  localparam logic [2:0] T_HIT  = 3'd4;
  localparam logic [2:0] T_MISS = 3'd5;
  localparam logic [2:0] T_OVER = 3'd6;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  reaction_game_multi_fsm_if #(
    .LED_NUM(18), .MAX_LEVEL(15), .LIVES(3), .GAME_S(60)
  ) bus ();

  reaction_game_multi_fsm #(
    .LED_NUM(18), .MAX_TARGETS(4), .BASE_WINDOW_MS(1000), .STEP_MS(150),
    .MIN_WINDOW_MS(250), .GAP_MS(500), .HITS_PER_LEVEL(5), .MAX_LEVEL(15),
    .LIVES(3), .GAME_S(60)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int hits     = 0;
  bit ans      = 1'b0;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (dbg_state !== s && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic hit_round(input string tag);
    wait_state(T_WAIT, 2000, tag);
    bus.switches = bus.switches ^ bus.led_on;
    step(1);
    check(tag, 32'(dbg_state), 32'(T_HIT));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(T_IDLE));
    check({tag, "_led"},   32'(bus.led_on), 32'h0);
    check({tag, "_score"}, 32'(bus.score), 32'd0);
    check({tag, "_level"}, 32'(bus.level), 32'd0);
    check({tag, "_lives"}, 32'(bus.lives_left), 32'd3);
    check({tag, "_time"},  32'(bus.time_left_s), 32'd60);
    check({tag, "_over"},  32'(bus.game_over), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.ms_tick    = 1'b1;
    bus.start_btn  = 1'b0;
    bus.switches   = '0;
    bus.rand_value = 5'd3;
    step(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    step(2);

    // 1: single target LED 3, mirror switch 3
    press_start();
    check("t1_gap_entry", 32'(dbg_state), 32'(T_GAP));
    step(499);
    check("t1_gap_499", 32'(dbg_state), 32'(T_GAP));
    step(1);
    check("t1_gap_500", 32'(dbg_state), 32'(T_PICK));
    step(1);
    check("t1_wait", 32'(dbg_state), 32'(T_WAIT));
    check("t1_led", 32'(bus.led_on), 32'h8);
    step(20);
    bus.switches = bus.switches ^ 18'h8;
    step(1);
    check("t1_hit", 32'(dbg_state), 32'(T_HIT));
    step(1);
    check("t1_score", 32'(bus.score), 32'd1);
    check("t1_lives", 32'(bus.lives_left), 32'd3);
    check("t1_level", 32'(bus.level), 32'd0);
    check("t1_led_gap", 32'(bus.led_on), 32'h0);

    for (int r = 0; r < 4; r++) hit_round("t1_more_hits");
    step(1);
    check("t1_score5", 32'(bus.score), 32'd5);
    check("t1_level1", 32'(bus.level), 32'd1);

    // 2: level 1, rand 7 constant -> 7 then probe to 8
    bus.rand_value = 5'd7;
    wait_state(T_WAIT, 1000, "t2_wait");
    check("t2_mask", 32'(bus.led_on), 32'h180);
    bus.switches = bus.switches ^ 18'h80;
    step(1);
    check("t2_partial", 32'(dbg_state), 32'(T_WAIT));
    step(5);
    check("t2_partial_hold", 32'(dbg_state), 32'(T_WAIT));

    // 4: correct (8) and wrong (0) toggles together -> MISS
    bus.switches = bus.switches ^ 18'h101;
    step(1);
    check("t4_miss", 32'(dbg_state), 32'(T_MISS));
    step(1);
    check("t4_lives", 32'(bus.lives_left), 32'd2);
    check("t4_score", 32'(bus.score), 32'd5);
    check("t4_gap", 32'(dbg_state), 32'(T_GAP));

    // abort during play
    step(10);
    press_start();
    check_reset_values("abort");
    step(1);

    // 3: three timeouts at level 0
    bus.rand_value = 5'd3;
    press_start();
    for (int r = 0; r < 3; r++) begin
      wait_state(T_WAIT, 1000, "t3_wait");
      step(999);
      check("t3_still_wait", 32'(dbg_state), 32'(T_WAIT));
      step(1);
      check("t3_timeout_miss", 32'(dbg_state), 32'(T_MISS));
      step(1);
      check("t3_lives", 32'(bus.lives_left), 32'(2 - r));
    end
    check("t3_over_state", 32'(dbg_state), 32'(T_OVER));
    check("t3_game_over", 32'(bus.game_over), 32'd1);
    check("t3_led_hold", 32'(bus.led_on), 32'h8);
    step(20);
    check("t3_led_hold2", 32'(bus.led_on), 32'h8);
    press_start();
    check_reset_values("t3_restart");
    step(1);

    // 5: play the full 60 s, answering every round until 59000 ms
    press_start();
    hits = 0;
    ans  = 1'b0;
    for (int k = 1; k <= 60000; k++) begin
      if (dbg_state == T_WAIT && !ans && k < 59000) begin
        bus.switches = bus.switches ^ bus.led_on;
        hits++;
        ans = 1'b1;
      end
      if (dbg_state != T_WAIT) ans = 1'b0;
      step(1);
      if (k == 59999) begin
        check("t5_time_1s", 32'(bus.time_left_s), 32'd1);
        check("t5_not_over", 32'(bus.game_over), 32'd0);
      end
    end
    // A window timeout coinciding with expiry shows MISS for one cycle first.
    if (dbg_state == T_MISS) step(1);
    check("t5_over_state", 32'(dbg_state), 32'(T_OVER));
    check("t5_time_zero", 32'(bus.time_left_s), 32'd0);
    check("t5_game_over", 32'(bus.game_over), 32'd1);
    check("t5_score", 32'(bus.score), 32'(hits));
    check("t5_level", 32'(bus.level), 32'((hits / 5 > 15) ? 15 : hits / 5));
    step(50);
    check("t5_score_frozen", 32'(bus.score), 32'(hits));
    check("t5_time_hold", 32'(bus.time_left_s), 32'd0);
    press_start();
    check_reset_values("t5_restart");
    step(1);

    // 6: async reset mid-WAIT with score 12
    press_start();
    for (int r = 0; r < 12; r++) hit_round("t6_hits");
    wait_state(T_WAIT, 2000, "t6_wait");
    check("t6_score12", 32'(bus.score), 32'd12);
    check("t6_level2", 32'(bus.level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    step(2);
    rst_n = 1'b1;
    step(2);
    check_reset_values("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
